sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares one single-port synchronous SRAM (1-cycle read latency) among NUM_REQ requesters. Typical requesters are the grouper/matcher address path and the encoder address path, which today contend for vocab/output memories through hard-wired muxes.
- Round-robin, one access per grant.
- Read data is broadcast on a single bus, with a per-requester valid strobe one cycle after the grant.
- Sits between the tokenizer control FSMs and a single sram instance.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ADDR_WIDTH, 4, SRAM address width
- DATA_WIDTH, 8, SRAM data width
- MAX_LOCK, 8, max consecutive locked grants (used only with SRAM_ARB_LOCK_EN)

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req  input  NUM_REQ  access request, one bit per requester
- req_we  input  NUM_REQ  1=write, 0=read, per requester
- req_addr  input  NUM_REQ*ADDR_WIDTH  flattened addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_din  input  NUM_REQ*DATA_WIDTH  flattened write data, same packing
- gnt  output  NUM_REQ  one-hot grant, same cycle as request
- rvalid  output  NUM_REQ  one-hot read-data-valid strobe
- rdata  output  DATA_WIDTH  read data, broadcast to all requesters
- sram_cs  output  1  SRAM chip select
- sram_we  output  1  SRAM write enable
- sram_addr  output  ADDR_WIDTH  SRAM address
- sram_din  output  DATA_WIDTH  SRAM write data
- sram_dout  input  DATA_WIDTH  SRAM read data

Behaviour:
- Clocking and reset: one clock (clk); reset rst_n is asynchronous and active-low. This is already decided.
- Reset values:
  - gnt=0, rvalid=0, rr_ptr=0, state=IDLE.
  - sram_cs=0, sram_we=0, sram_addr=0, sram_din=0.
  - lock_cnt=0.
- Grant:
  - gnt is combinational from req, rr_ptr and state; at most one bit is set.
  - Winner = first i with req[i]=1, searching from rr_ptr upward modulo NUM_REQ.
  - On grant to i, rr_ptr <= (i+1) mod NUM_REQ at the clock edge. Wrap from NUM_REQ-1 to 0.
  - No request: gnt=0, sram_cs=0, rr_ptr unchanged.
- Handshake:
  - A requester holds req, req_we, req_addr and req_din stable until it samples gnt=1 at a clock edge.
  - One access is completed per grant.
  - A requester may keep req high to issue back-to-back accesses; if it is the sole requester it is granted every cycle.
- SRAM drive:
  - While gnt[i]=1: sram_cs=1, sram_we=req_we[i], sram_addr and sram_din = slice i. These are a combinational mux, with no added latency.
  - When idle: all SRAM outputs are 0.
- Read return:
  - A read granted in cycle T gives rvalid[i]=1 in cycle T+1 only.
  - rdata = sram_dout (pass-through); it is valid only while some rvalid bit is set.
  - A granted write produces no rvalid.
- Simultaneous events:
  - A new grant in T+1 is allowed while rvalid from T is high; full throughput is 1 access/cycle.
  - Write and read to the same address in consecutive cycles: the read returns the new data, since the write is committed at the T edge.
- States:
  - IDLE: no grant this cycle.
  - ACCESS: the grant issued last cycle was unlocked.
  - LOCKED: feature only.
  - Transitions: IDLE/ACCESS -> ACCESS on any grant; -> IDLE on no request.
- Reset mid-operation: rvalid is cleared immediately (asynchronously); pending read data is discarded; rr_ptr returns to 0. Requesters must re-request.
- Width rule: rr_ptr is $clog2(NUM_REQ) bits, with explicit modulo when NUM_REQ is not a power of two.

Optional Feature:
- Macro SRAM_ARB_LOCK_EN.
- Enabled:
  - Adds input lock, NUM_REQ bits.
  - If the winner i has lock[i]=1 when granted, the FSM enters LOCKED with owner=i and lock_cnt=1.
  - In LOCKED, gnt goes only to the owner while req[owner]=1, and lock_cnt increments.
  - LOCKED exits to round-robin arbitration (rr_ptr=owner+1) when any of these occurs:
    - req[owner]=0
    - lock[owner]=0
    - lock_cnt reaches MAX_LOCK. The owner is then ineligible for that one arbitration cycle if others request.
  - rvalid timing is unchanged.
- Disabled: no lock port, no LOCKED state, pure round-robin.

Test Plan:
1. Reset, then req=3'b001 read, addr 5, memory[5]=0xA7 -> gnt=001 in same cycle, sram_addr=5, next cycle rvalid=001 and rdata=0xA7.
2. req=3'b111 held 6 cycles, all reads -> gnt sequence 001,010,100,001,010,100, with rvalid following one cycle later each time.
3. Requester 1 writes 0x3C to addr 9 in cycle T, requester 2 reads addr 9 in T+1 -> rvalid=100 at T+2, rdata=0x3C, no rvalid at T+1.
4. rr_ptr=2, req=3'b011 -> gnt=001 (wrap), then rr_ptr=1, next gnt=010.
5. Read granted, then rst_n pulsed low mid-cycle before rvalid -> rvalid=0 immediately, gnt=0, rr_ptr=0 after release.
6. (SRAM_ARB_LOCK_EN, MAX_LOCK=4) req=011, lock=001 -> gnt=001 for 4 cycles, then gnt=010 once, then 001 resumes.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters
// Optional consecutive-grant locking is built when SRAM_ARB_LOCK_EN is defined.
module sram_port_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_LOCK   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_din,
`ifdef SRAM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]            lock,
`endif
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata,
    output logic                          sram_cs,
    output logic                          sram_we,
    output logic [ADDR_WIDTH-1:0]         sram_addr,
    output logic [DATA_WIDTH-1:0]         sram_din,
    input  logic [DATA_WIDTH-1:0]         sram_dout
);

    localparam int PTR_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_LOCK < 1) begin : g_bad_param
        $error("sram_port_arbiter: parameter out of range");
    end

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic [1:0] {IDLE, ACCESS, LOCKED} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

    state_t             state, state_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_ptr_nxt;
    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   win_nxt;
    logic               found;
    logic [NUM_REQ-1:0] gnt_c;
    logic [NUM_REQ-1:0] rd_q;

    // First eligible requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        int idx;
        idx     = 0;
        rr_gnt  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && elig[idx]) begin
                found       = 1'b1;
                win_idx     = PTR_W'(idx);
                rr_gnt[idx] = 1'b1;
            end
        end
    end

    assign win_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;

`ifdef SRAM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_LOCK + 1);

    logic [PTR_W-1:0]   owner, owner_nxt;
    logic [CNT_W-1:0]   lock_cnt, lock_cnt_nxt;
    logic [NUM_REQ-1:0] owner_oh;
    logic [PTR_W-1:0]   owner_inc;
    logic               hold;
    logic               expired;

    assign owner_oh  = NUM_REQ'(1) << owner;
    assign owner_inc = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign expired   = (state == LOCKED) && (lock_cnt == CNT_W'(MAX_LOCK));
    assign hold      = (state == LOCKED) && req[owner] && lock[owner] && !expired;

    // An owner whose lock ran out sits out one arbitration if anyone else is waiting.
    always_comb begin
        elig = req;
        if (expired && ((req & ~owner_oh) != '0))
            elig = req & ~owner_oh;
    end

    always_comb begin
        gnt_c        = '0;
        state_nxt    = IDLE;
        rr_ptr_nxt   = rr_ptr;
        owner_nxt    = owner;
        lock_cnt_nxt = '0;
        if (hold) begin
            gnt_c        = owner_oh;
            state_nxt    = LOCKED;
            rr_ptr_nxt   = owner_inc;
            lock_cnt_nxt = lock_cnt + 1'b1;
        end else if (found) begin
            gnt_c      = rr_gnt;
            rr_ptr_nxt = win_nxt;
            if (lock[win_idx]) begin
                state_nxt    = LOCKED;
                owner_nxt    = win_idx;
                lock_cnt_nxt = CNT_W'(1);
            end else begin
                state_nxt = ACCESS;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            owner    <= owner_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end
`else
    assign elig = req;

    always_comb begin
        gnt_c      = '0;
        state_nxt  = IDLE;
        rr_ptr_nxt = rr_ptr;
        if (found) begin
            gnt_c      = rr_gnt;
            state_nxt  = ACCESS;
            rr_ptr_nxt = win_nxt;
        end
    end
`endif

    // Grants are suppressed while reset is held so the SRAM sees no access.
    assign gnt = rst_n ? gnt_c : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rr_ptr <= '0;
            rd_q   <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            rd_q   <= gnt & ~req_we;
        end
    end

    // Read strobes only exist in the cycle after a grant was issued.
    assign rvalid = (state != IDLE) ? rd_q : '0;
    assign rdata  = sram_dout;

    always_comb begin
        sram_cs   = |gnt;
        sram_we   = 1'b0;
        sram_addr = '0;
        sram_din  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sram_we   = req_we[i];
                sram_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sram_din  = req_din[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req;
    logic [2:0]  req_we;
    logic [11:0] req_addr;
    logic [23:0] req_din;
`ifdef SRAM_ARB_LOCK_EN
    logic [2:0]  lock;
`endif
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [7:0]  rdata;
    logic        sram_cs;
    logic        sram_we;
    logic [3:0]  sram_addr;
    logic [7:0]  sram_din;
    logic [7:0]  sram_dout;

    logic [7:0]  mem [16];

    int vectors     = 0;
    int miscompares = 0;

    sram_port_arbiter #(
        .NUM_REQ   (3),
        .ADDR_WIDTH(4),
        .DATA_WIDTH(8),
        .MAX_LOCK  (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_we   (req_we),
        .req_addr (req_addr),
        .req_din  (req_din),
`ifdef SRAM_ARB_LOCK_EN
        .lock     (lock),
`endif
        .gnt      (gnt),
        .rvalid   (rvalid),
        .rdata    (rdata),
        .sram_cs  (sram_cs),
        .sram_we  (sram_we),
        .sram_addr(sram_addr),
        .sram_din (sram_din),
        .sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    // Memory word i resets to 0xA2 ^ i, so mem[5]=A7, mem[9]=AB.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= 8'hA2 ^ 8'(i);
            sram_dout <= 8'h00;
        end else if (sram_cs) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout      <= mem[sram_addr];
        end
    end

    task automatic clear_inputs();
        req      = '0;
        req_we   = '0;
        req_addr = '0;
        req_din  = '0;
`ifdef SRAM_ARB_LOCK_EN
        lock     = '0;
`endif
    endtask

    task automatic drive(input int i, input logic we, input logic [3:0] a, input logic [7:0] d);
        req[i]            = 1'b1;
        req_we[i]         = we;
        req_addr[i*4 +: 4] = a;
        req_din[i*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 1'b0, 4'd3, 8'h11);
        drive(1, 1'b1, 4'd4, 8'h22);
        #1;
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL reset_gnt got %b want %b", gnt, 3'b000); end
        vectors++;
        if (rvalid !== 3'b000) begin miscompares++; $display("FAIL reset_rvalid got %b want %b", rvalid, 3'b000); end
        vectors++;
        if ({sram_cs, sram_we, sram_addr, sram_din} !== 14'h0) begin
            miscompares++;
            $display("FAIL reset_sram got cs=%b we=%b addr=%h din=%h want all zero", sram_cs, sram_we, sram_addr, sram_din);
        end
        do_reset();
    endtask

    task automatic test_single_read();
        do_reset();
        drive(0, 1'b0, 4'd5, 8'h00);
        #1;
        vectors++;
        if (gnt !== 3'b001) begin miscompares++; $display("FAIL single_gnt got %b want %b", gnt, 3'b001); end
        vectors++;
        if ({sram_cs, sram_we, sram_addr} !== {1'b1, 1'b0, 4'd5}) begin
            miscompares++;
            $display("FAIL single_sram got cs=%b we=%b addr=%0d want cs=1 we=0 addr=5", sram_cs, sram_we, sram_addr);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        vectors++;
        if (rvalid !== 3'b001) begin miscompares++; $display("FAIL single_rvalid got %b want %b", rvalid, 3'b001); end
        vectors++;
        if (rdata !== 8'hA7) begin miscompares++; $display("FAIL single_rdata got %h want %h", rdata, 8'hA7); end
        @(negedge clk);
        #1;
        vectors++;
        if (rvalid !== 3'b000) begin miscompares++; $display("FAIL single_rvalid_once got %b want %b", rvalid, 3'b000); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_g;
        logic [2:0] prev_g;
        logic [7:0] prev_d;
        do_reset();
        drive(0, 1'b0, 4'd1, 8'h00);
        drive(1, 1'b0, 4'd2, 8'h00);
        drive(2, 1'b0, 4'd3, 8'h00);
        prev_g = 3'b000;
        prev_d = 8'h00;
        for (int k = 0; k < 6; k++) begin
            exp_g = 3'b001 << (k % 3);
            #1;
            vectors++;
            if (gnt !== exp_g) begin miscompares++; $display("FAIL rr_gnt[%0d] got %b want %b", k, gnt, exp_g); end
            vectors++;
            if (rvalid !== prev_g) begin miscompares++; $display("FAIL rr_rvalid[%0d] got %b want %b", k, rvalid, prev_g); end
            if (k > 0) begin
                vectors++;
                if (rdata !== prev_d) begin miscompares++; $display("FAIL rr_rdata[%0d] got %h want %h", k, rdata, prev_d); end
            end
            prev_g = exp_g;
            prev_d = 8'hA2 ^ 8'((k % 3) + 1);
            @(negedge clk);
        end
        clear_inputs();
        #1;
        vectors++;
        if (gnt !== 3'b000) begin miscompares++; $display("FAIL rr_idle_gnt got %b want %b", gnt, 3'b000); end
        vectors++;
        if (rvalid !== 3'b100 || rdata !== 8'hA1) begin
            miscompares++;
            $display("FAIL rr_last got rvalid=%b rdata=%h want rvalid=100 rdata=a1", rvalid, rdata);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(2, 1'b0, 4'd3, 8'h00);
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++;
            if (gnt !== 3'b100) begin miscompares++; $display("FAIL b2b_gnt[%0d] got %b want %b", k, gnt, 3'b100); end
            if (k > 0) begin
                vectors++;
                if (rvalid !== 3'b100 || rdata !== 8'hA1) begin
                    miscompares++;
                    $display("FAIL b2b_read[%0d] got rvalid=%b rdata=%h want rvalid=100 rdata=a1", k, rvalid, rdata);
                end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_write_then_read();
        do_reset();
        drive(1, 1'b1, 4'd9, 8'h3C);
        #1;
        vectors++;
        if (gnt !== 3'b010 || sram_we !== 1'b1 || sram_din !== 8'h3C || sram_addr !== 4'd9) begin
            miscompares++;
            $display("FAIL raw_write got gnt=%b we=%b addr=%0d din=%h want gnt=010 we=1 addr=9 din=3c", gnt, sram_we, sram_addr, sram_din);
        end
        @(negedge clk);
        clear_inputs();
        drive(2, 1'b0, 4'd9, 8'h00);
        #1;
        vectors++;
        if (gnt !== 3'b100) begin miscompares++; $display("FAIL raw_read_gnt got %b want %b", gnt, 3'b100); end
        vectors++;
        if (rvalid !== 3'b000) begin miscompares++; $display("FAIL raw_no_wr_rvalid got %b want %b", rvalid, 3'b000); end
        @(negedge clk);
        clear_inputs();
        #1;
        vectors++;
        if (rvalid !== 3'b100 || rdata !== 8'h3C) begin
            miscompares++;
            $display("FAIL raw_rdata got rvalid=%b rdata=%h want rvalid=100 rdata=3c", rvalid, rdata);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        drive(1, 1'b0, 4'd0, 8'h00);
        #1;
        vectors++;
        if (gnt !== 3'b010) begin miscompares++; $display("FAIL wrap_setup got %b want %b", gnt, 3'b010); end
        @(negedge clk);
        drive(0, 1'b0, 4'd0, 8'h00);
        #1;
        vectors++;
        if (gnt !== 3'b001) begin miscompares++; $display("FAIL wrap_gnt got %b want %b", gnt, 3'b001); end
        @(negedge clk);
        #1;
        vectors++;
        if (gnt !== 3'b010) begin miscompares++; $display("FAIL wrap_next got %b want %b", gnt, 3'b010); end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(0, 1'b0, 4'd5, 8'h00);
        @(posedge clk);
        #1;
        vectors++;
        if (rvalid !== 3'b001) begin miscompares++; $display("FAIL mid_pre_rvalid got %b want %b", rvalid, 3'b001); end
        #1;
        clear_inputs();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rvalid !== 3'b000 || gnt !== 3'b000) begin
            miscompares++;
            $display("FAIL mid_reset got rvalid=%b gnt=%b want rvalid=000 gnt=000", rvalid, gnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b0, 4'd1, 8'h00);
        drive(1, 1'b0, 4'd2, 8'h00);
        #1;
        vectors++;
        if (gnt !== 3'b001) begin miscompares++; $display("FAIL mid_ptr_cleared got %b want %b", gnt, 3'b001); end
        @(negedge clk);
        clear_inputs();
    endtask

`ifdef SRAM_ARB_LOCK_EN
    task automatic test_lock();
        logic [2:0] exp_seq [7];
        exp_seq = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b010, 3'b001, 3'b001};
        do_reset();
        drive(0, 1'b0, 4'd1, 8'h00);
        drive(1, 1'b0, 4'd2, 8'h00);
        lock = 3'b001;
        for (int k = 0; k < 7; k++) begin
            #1;
            vectors++;
            if (gnt !== exp_seq[k]) begin miscompares++; $display("FAIL lock_gnt[%0d] got %b want %b", k, gnt, exp_seq[k]); end
            @(negedge clk);
        end
        clear_inputs();
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_read();
        test_round_robin();
        test_back_to_back();
        test_write_then_read();
        test_wrap();
        test_reset_mid();
`ifdef SRAM_ARB_LOCK_EN
        test_lock();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
